// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM:
// state codes, opcodes, ALU/mux selector codes and the control bundle.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] ALUSRCB_REG     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of FSM state (and mem_ready in FETCH) into datapath controls.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = ALUSRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_REG;
                ctrl_o.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = ALUSRCB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath: instruction sequencing,
// retire/illegal pulses and the retired-instruction counter.
module multicycle_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             retire,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    ctrl_t            ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            // Codes 12-15 are unreachable; recover to FETCH.
            default:     state_d = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized bench for multicycle_main_control: per-instruction expected cycle
// sequences are built from the instruction class and checked every cycle.
module tb_multicycle_main_control;

    localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4,
                   MEM_WRITE = 5, R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9,
                   ADDI_EXEC = 10, ADDI_WB = 11;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic        retire, illegal_op;
    logic [31:0] instr_count;

    logic        s_pcw, s_pcwc, s_iord, s_mrd, s_mwr, s_irw, s_m2r, s_rdst, s_rw, s_asa;
    logic [1:0]  s_asb, s_aop, s_pcs;
    logic [3:0]  s_state;
    logic        s_retire, s_illegal;
    logic [3:0]  cnt4;

    logic [15:0] ctrl_v;
    assign ctrl_v = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    always #5 clk = ~clk;

    multicycle_main_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .retire(retire), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    multicycle_main_control #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(s_pcw), .PCWriteCond(s_pcwc), .IorD(s_iord), .MemRead(s_mrd),
        .MemWrite(s_mwr), .IRWrite(s_irw), .MemtoReg(s_m2r), .RegDst(s_rdst),
        .RegWrite(s_rw), .ALUSrcA(s_asa), .ALUSrcB(s_asb), .ALUOp(s_aop),
        .PCSource(s_pcs), .state(s_state), .retire(s_retire), .illegal_op(s_illegal),
        .instr_count(cnt4)
    );

    typedef struct {
        int st;
        bit mr;
        bit ret;
        bit ill;
    } step_t;

    step_t       q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected control word, listed per state straight from the control table.
    function automatic logic [15:0] exp_ctrl(input int st, input bit mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            FETCH:               begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            DECODE:              asb = 2'b11;
            MEM_ADDR, ADDI_EXEC: begin asa = 1; asb = 2'b10; end
            MEM_READ:            begin mrd = 1; iord = 1; end
            MEM_WRITE:           begin mwr = 1; iord = 1; end
            MEM_WB:              begin rw = 1; m2r = 1; end
            R_EXEC:              begin asa = 1; aop = 2'b10; end
            R_WB:                begin rw = 1; rdst = 1; end
            BRANCH:              begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            JUMP:                begin pcw = 1; pcs = 2'b10; end
            ADDI_WB:             rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs};
    endfunction

    task automatic push(input int st, input bit mr, input bit ret, input bit ill);
        step_t s;
        s.st = st; s.mr = mr; s.ret = ret; s.ill = ill;
        q.push_back(s);
    endtask

    task automatic push_wait(input int st, input int w, input bit ret_on_done);
        for (int i = 0; i < w; i++) push(st, 1'b0, 1'b0, 1'b0);
        push(st, 1'b1, ret_on_done, 1'b0);
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic build(input logic [5:0] opc, input int w0, input int w1);
        push_wait(FETCH, w0, 1'b0);
        case (opc)
            6'b000000: begin push(DECODE, rb(), 0, 0); push(R_EXEC, rb(), 0, 0); push(R_WB, rb(), 1, 0); end
            6'b100011: begin push(DECODE, rb(), 0, 0); push(MEM_ADDR, rb(), 0, 0);
                             push_wait(MEM_READ, w1, 1'b0); push(MEM_WB, rb(), 1, 0); end
            6'b101011: begin push(DECODE, rb(), 0, 0); push(MEM_ADDR, rb(), 0, 0);
                             push_wait(MEM_WRITE, w1, 1'b1); end
            6'b000100: begin push(DECODE, rb(), 0, 0); push(BRANCH, rb(), 1, 0); end
            6'b000010: begin push(DECODE, rb(), 0, 0); push(JUMP, rb(), 1, 0); end
            6'b001000: begin push(DECODE, rb(), 0, 0); push(ADDI_EXEC, rb(), 0, 0); push(ADDI_WB, rb(), 1, 0); end
            default:   push(DECODE, rb(), 0, 1);
        endcase
    endtask

    task automatic play();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            #1;
            chk("state",   {28'd0, state}, s.st);
            chk("ctrl",    {16'd0, ctrl_v}, {16'd0, exp_ctrl(s.st, s.mr)});
            chk("retire",  {31'd0, retire}, {31'd0, s.ret});
            chk("illegal", {31'd0, illegal_op}, {31'd0, s.ill});
            chk("count",   instr_count, exp_cnt);
            chk("count4",  {28'd0, cnt4}, {28'd0, exp_cnt[3:0]});
            if (s.ret) exp_cnt++;
        end
    endtask

    task automatic run_instr(input logic [5:0] opc, input int w0, input int w1);
        @(posedge clk);
        #1 opcode = opc;
        build(opc, w0, w1);
        play();
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] opc;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;

        reset = 1'b1; mem_ready = 1'b0; opcode = 6'd0;
        #12;
        chk("rst_state", {28'd0, state}, FETCH);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_ctrl",  {16'd0, ctrl_v}, {16'd0, exp_ctrl(FETCH, 1'b0)});
        @(negedge clk);
        reset = 1'b0;

        run_instr(6'b100011, 0, 0);
        run_instr(6'b101011, 0, 3);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 1, 0);
        run_instr(6'b001000, 0, 0);
        run_instr(6'b111111, 0, 0);
        chk("ill_cnt", instr_count, 32'd6);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 6) == 6) opc = 6'($urandom_range(0, 63));
            else opc = ops[$urandom_range(0, 5)];
            run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of an R-type execute cycle.
        @(posedge clk);
        #1 opcode = 6'b000000;
        push_wait(FETCH, 0, 1'b0);
        push(DECODE, 1'b1, 0, 0);
        play();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("pre_rst_state", {28'd0, state}, R_EXEC);
        #1 reset = 1'b1;
        #1;
        chk("arst_state",  {28'd0, state}, FETCH);
        chk("arst_count",  instr_count, 32'd0);
        chk("arst_count4", {28'd0, cnt4}, 32'd0);
        chk("arst_ctrl",   {16'd0, ctrl_v}, {16'd0, exp_ctrl(FETCH, 1'b0)});
        chk("arst_retire", {31'd0, retire}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = '0;

        for (int i = 0; i < 16; i++) run_instr(6'b000010, 0, 0);
        @(negedge clk);
        #1;
        chk("wrap4",  {28'd0, cnt4}, 32'd0);
        chk("cnt16",  instr_count, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback per instruction, and drives the ALUOp code consumed by the ALU control decoder.
- Supports R-type, lw, sw, beq, j and addi.
- Memory states hold on a mem_ready handshake; completion is reported through a retire pulse and an instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
opcode  in  6  IR[31:26], stable from DECODE onward
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write gated by ALU zero (beq)
IorD  out  1  0=PC address, 1=ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  0=ALUOut, 1=MDR to register file
RegDst  out  1  0=rt, 1=rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUOp  out  2  00=add, 01=sub, 10=R-type funct
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
state  out  4  current state, for debug
retire  out  1  one-cycle pulse on instruction completion
illegal_op  out  1  one-cycle pulse on unsupported opcode
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset: asynchronous and active-high. State goes to FETCH (0) and instr_count to 0 immediately.
- Outputs after reset are the FETCH decode.
- Reset mid-instruction aborts it: no retire pulse and no count.
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11
  - Codes 12-15 go to FETCH next cycle with all outputs 0.
- Outputs are combinational from state, plus mem_ready where noted. Any signal not listed for a state is 0.
- Per-state outputs:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - MEM_ADDR and ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEM_READ: MemRead=1, IorD=1.
  - MEM_WRITE: MemWrite=1, IorD=1.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0.
- Transitions:
  - FETCH stays in FETCH while !mem_ready, else goes to DECODE.
  - DECODE dispatches on opcode:
    - 000000 -> R_EXEC
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EXEC
    - any other opcode -> FETCH, with illegal_op=1 in that DECODE cycle
  - MEM_ADDR goes to MEM_READ if opcode=100011, else to MEM_WRITE.
  - MEM_READ stays until mem_ready, then goes to MEM_WB.
  - MEM_WRITE stays until mem_ready, then goes to FETCH.
  - R_EXEC -> R_WB. ADDI_EXEC -> ADDI_WB.
  - MEM_WB, R_WB, BRANCH, JUMP and ADDI_WB all go to FETCH.
- retire is 1 in MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB, and in MEM_WRITE when mem_ready=1.
- instr_count increments on each clock edge where retire=1, and wraps from all-ones to 0.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each wait cycle with mem_ready=0 adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- Outputs hold stable throughout a wait. mem_ready is ignored in every other state.
- Only the state register and instr_count are sequential. No latches.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALUOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_RTYPE=10)
  - ALUSrcB and PCSource selector codes
- Sub-module mc_ctrl_outdec is the purely combinational mapping of state and mem_ready to control outputs.
- The FSM's next-state logic, instr_count and the pulse outputs stay in the top module.

Test Plan:
- Reset asserted mid-R_EXEC, asynchronously between edges -> state=0 immediately, instr_count=0, outputs MemRead=1, ALUSrcB=01, IRWrite=0 while mem_ready=0.
- lw (opcode 100011), mem_ready=1 -> state sequence 0,1,2,3,4,0 over 5 cycles; MEM_WB has RegWrite=1 and MemtoReg=1; retire pulses once; instr_count 0->1.
- sw (101011) with mem_ready low for 3 cycles in MEM_WRITE -> MemWrite=1 and IorD=1 held for 4 cycles; retire only in the mem_ready cycle; no RegWrite at any point.
- R-type (000000) then beq (000100) -> ALUOp=10 in R_EXEC; R_WB has RegDst=1; BRANCH has ALUOp=01, PCWriteCond=1, PCSource=01; total 7 cycles; instr_count=2.
- j (000010) then addi (001000) -> JUMP has PCWrite=1, PCSource=10; ADDI_EXEC has ALUSrcB=10, ALUOp=00; ADDI_WB has RegWrite=1, RegDst=0.
- Opcode 111111 -> illegal_op=1 for exactly one cycle in DECODE, next state=0, retire=0, instr_count unchanged. Separately, with CNT_W=4, 16 retirements -> instr_count wraps to 0.
